// File: rtl/io_guard_pkg.sv
// Shared types and constants for the pad-side project switch guard.
// Holds the handover FSM encoding, counter sizing helper and readback width.
// No logic here; imported by the guard top and its sub-blocks.
package io_guard_pkg;

  // Handover FSM: DRAIN tristates everything, APPLY releases output enables,
  // IDLE passes harness traffic straight through.
  typedef enum logic [1:0] {
    ST_DRAIN = 2'd0,
    ST_APPLY = 2'd1,
    ST_IDLE  = 2'd2
  } guard_state_e;

  // Width of the switch-event readback counter.
  localparam int SWITCH_COUNT_W = 16;

  // Guard counter must hold values up to GUARD_CYCLES.
  function automatic int guard_cnt_w(input int guard_cycles);
    return $clog2(guard_cycles + 1);
  endfunction

endpackage

// File: rtl/io_in_synchronizer.sv
// Multi-flop synchroniser for raw pad inputs, one chain per pad bit.
// Latency: SYNC_STAGES cycles from io pad to q_o.
// No backpressure: samples every cycle unconditionally.
module io_in_synchronizer #(
  parameter int NUM_PADS    = 38,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_PADS-1:0] d_i,
  output logic [NUM_PADS-1:0] q_o
);

  logic [NUM_PADS-1:0] stage_q [SYNC_STAGES];

  // Shift the pad sample through the flop chain; first stage may go metastable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/io_switch_guard.sv
// Break-before-make guard between the harness output mux and the user pads.
// Latency: 1 cycle out/oeb to pads in IDLE; SYNC_STAGES+1 cycles io_in to harness.
// No backpressure: a project change always preempts and restarts the guard.
module io_switch_guard
  import io_guard_pkg::*;
#(
  parameter int NUM_PADS     = 38,
  parameter int GUARD_CYCLES = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [7:0]                active_project_i,
  input  logic [NUM_PADS-1:0]       oeb_i,
  input  logic [NUM_PADS-1:0]       out_i,
  input  logic [NUM_PADS-1:0]       io_in,
  output logic [NUM_PADS-1:0]       io_out,
  output logic [NUM_PADS-1:0]       io_oeb,
  output logic [NUM_PADS-1:0]       sync_io_in_o,
  output logic                      busy_o,
  output logic [SWITCH_COUNT_W-1:0] switch_count_o
);

  localparam int              CNT_W      = guard_cnt_w(GUARD_CYCLES);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [SWITCH_COUNT_W-1:0] SWITCH_MAX = '1;

  guard_state_e              state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [7:0]                last_project_q;
  logic                      first_q;
  logic                      proj_change;
  logic                      handover_done;
  logic [SWITCH_COUNT_W-1:0] switch_cnt_q, switch_cnt_d;

  logic [NUM_PADS-1:0]       io_out_q, io_out_d;
  logic [NUM_PADS-1:0]       io_oeb_q, io_oeb_d;
  logic [NUM_PADS-1:0]       sync_q, sync_d;
  logic                      busy_q, busy_d;
  logic [NUM_PADS-1:0]       sync_w;

  // The synchroniser free-runs in every state; only its output is gated below.
  io_in_synchronizer #(
    .NUM_PADS    (NUM_PADS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .d_i   (io_in),
    .q_o   (sync_w)
  );

  // The first edge after reset captures the project select as the baseline
  // rather than treating whatever was on the bus as a change.
  assign proj_change = !first_q && (active_project_i != last_project_q);

  // Next-state: a project change always wins and restarts the drain.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    handover_done = 1'b0;
    if (proj_change) begin
      state_d = ST_DRAIN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_DRAIN: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == GUARD_LAST) begin
            state_d = ST_APPLY;
          end
        end
        ST_APPLY: begin
          state_d       = ST_IDLE;
          handover_done = 1'b1;
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Readback counter of completed handovers, sticks at all ones.
  always_comb begin
    switch_cnt_d = switch_cnt_q;
    if (handover_done && (switch_cnt_q != SWITCH_MAX)) begin
      switch_cnt_d = switch_cnt_q + 1'b1;
    end
  end

  // Output targets follow the state being entered, so the pads go tristate
  // on the very edge that sees the project change.
  always_comb begin
    io_out_d = '0;
    io_oeb_d = '1;
    sync_d   = '0;
    busy_d   = 1'b1;
    case (state_d)
      ST_APPLY: begin
        io_oeb_d = oeb_i;
      end
      ST_IDLE: begin
        io_out_d = out_i;
        io_oeb_d = oeb_i;
        sync_d   = sync_w;
        busy_d   = 1'b0;
      end
      default: begin
        io_out_d = '0;
      end
    endcase
  end

  // FSM, guard counter, project tracking and switch counter state.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q        <= ST_DRAIN;
      cnt_q          <= '0;
      last_project_q <= '0;
      first_q        <= 1'b1;
      switch_cnt_q   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_project_q <= active_project_i;
      first_q        <= 1'b0;
      switch_cnt_q   <= switch_cnt_d;
    end
  end

  // Registered pad-side outputs; reset leaves every pad tristate and quiet.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      io_out_q <= '0;
      io_oeb_q <= '1;
      sync_q   <= '0;
      busy_q   <= 1'b1;
    end else begin
      io_out_q <= io_out_d;
      io_oeb_q <= io_oeb_d;
      sync_q   <= sync_d;
      busy_q   <= busy_d;
    end
  end

  assign io_out         = io_out_q;
  assign io_oeb         = io_oeb_q;
  assign sync_io_in_o   = sync_q;
  assign busy_o         = busy_q;
  assign switch_count_o = switch_cnt_q;

endmodule

// File: tb/tb_io_switch_guard.sv
// Directed bench for io_switch_guard: reset settle, pass-through table,
// guard restarts, input gating and asynchronous reset.
module tb_io_switch_guard;

  localparam int NP = 38;
  localparam logic [NP-1:0] ONES = '1;
  localparam logic [NP-1:0] PAT  = 38'h0F_0000_00F0;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    proj;
  logic [NP-1:0] oeb_in, out_in, pad_in;
  logic [NP-1:0] io_out, io_oeb, sync_out;
  logic          busy;
  logic [15:0]   swcnt;

  int n_checks = 0;
  int n_fail   = 0;

  io_switch_guard #(
    .NUM_PADS     (NP),
    .GUARD_CYCLES (16),
    .SYNC_STAGES  (2)
  ) dut (
    .wb_clk_i         (clk),
    .wb_rst_i         (rst),
    .active_project_i (proj),
    .oeb_i            (oeb_in),
    .out_i            (out_in),
    .io_in            (pad_in),
    .io_out           (io_out),
    .io_oeb           (io_oeb),
    .sync_io_in_o     (sync_out),
    .busy_o           (busy),
    .switch_count_o   (swcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    proj;
    logic [NP-1:0] out;
    logic [NP-1:0] oeb;
    logic [NP-1:0] exp_out;
    logic [NP-1:0] exp_oeb;
    logic          exp_busy;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; sample 1ns after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // IDLE rows on project 0, then a project change to 2 in the last row.
    vecs[0] = '{8'd0, ONES,            '0,              ONES,            '0,              1'b0};
    vecs[1] = '{8'd0, 38'h15_5555_5555, 38'h2A_AAAA_AAAA, 38'h15_5555_5555, 38'h2A_AAAA_AAAA, 1'b0};
    vecs[2] = '{8'd0, '0,              38'h00_0000_0100, '0,              38'h00_0000_0100, 1'b0};
    vecs[3] = '{8'd0, '0,              '0,              '0,              '0,              1'b0};
    vecs[4] = '{8'd0, ONES,            '0,              ONES,            '0,              1'b0};
    vecs[5] = '{8'd2, ONES,            '0,              '0,              ONES,            1'b1};

    rst = 1'b0; proj = 8'd0; oeb_in = '0; out_in = '0; pad_in = '0;
    #2 rst = 1'b1;
    tick(); tick();
    check("rst_io_out", 64'(io_out), 64'(0));
    check("rst_io_oeb", 64'(io_oeb), 64'(ONES));
    check("rst_sync",   64'(sync_out), 64'(0));
    check("rst_busy",   64'(busy), 64'(1));
    check("rst_count",  64'(swcnt), 64'(0));

    // Reset release: 16 cycles tristate, APPLY on edge 16, IDLE on edge 17.
    rst = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      check("settle_oeb", 64'(io_oeb), (e < 16) ? 64'(ONES) : 64'(0));
      check("settle_busy", 64'(busy), 64'(1));
    end
    check("settle_count_pre", 64'(swcnt), 64'(0));
    tick();
    check("settle_busy_fall", 64'(busy), 64'(0));
    check("settle_count", 64'(swcnt), 64'(1));

    // Table: pass-through in IDLE, last row triggers a handover.
    for (int i = 0; i < 6; i++) begin
      proj = vecs[i].proj; out_in = vecs[i].out; oeb_in = vecs[i].oeb;
      tick();
      check("vec_io_out", 64'(io_out), 64'(vecs[i].exp_out));
      check("vec_io_oeb", 64'(io_oeb), 64'(vecs[i].exp_oeb));
      check("vec_busy",   64'(busy), 64'(vecs[i].exp_busy));
    end
    for (int j = 1; j <= 15; j++) begin
      tick();
      check("chg_io_out", 64'(io_out), 64'(0));
      check("chg_io_oeb", 64'(io_oeb), 64'(ONES));
    end
    tick();
    check("chg_apply_out", 64'(io_out), 64'(0));
    check("chg_apply_oeb", 64'(io_oeb), 64'(0));
    check("chg_apply_busy", 64'(busy), 64'(1));
    check("chg_apply_count", 64'(swcnt), 64'(1));
    tick();
    check("chg_idle_out", 64'(io_out), 64'(ONES));
    check("chg_idle_busy", 64'(busy), 64'(0));
    check("chg_count", 64'(swcnt), 64'(2));

    // Input gating plus restarts: change at DRAIN cycle 10, then during APPLY.
    pad_in = ONES; oeb_in = PAT;
    for (int j = 0; j < 4; j++) tick();
    check("idle_sync_ones", 64'(sync_out), 64'(ONES));
    proj = 8'd3;
    tick();
    check("rs1_oeb", 64'(io_oeb), 64'(ONES));
    check("rs1_sync", 64'(sync_out), 64'(0));
    for (int j = 1; j <= 10; j++) begin
      tick();
      check("rs1_drain_oeb", 64'(io_oeb), 64'(ONES));
      check("rs1_drain_sync", 64'(sync_out), 64'(0));
    end
    proj = 8'd4;
    tick();
    check("rs2_oeb", 64'(io_oeb), 64'(ONES));
    for (int j = 1; j <= 15; j++) begin
      tick();
      check("rs2_drain_oeb", 64'(io_oeb), 64'(ONES));
      check("rs2_drain_out", 64'(io_out), 64'(0));
      check("rs2_drain_sync", 64'(sync_out), 64'(0));
    end
    tick();
    check("rs2_apply_oeb", 64'(io_oeb), 64'(PAT));
    check("rs2_apply_sync", 64'(sync_out), 64'(0));
    check("rs2_apply_busy", 64'(busy), 64'(1));
    proj = 8'd5;
    tick();
    check("rs3_oeb", 64'(io_oeb), 64'(ONES));
    check("rs3_count", 64'(swcnt), 64'(2));
    for (int j = 1; j <= 15; j++) begin
      tick();
      check("rs3_drain_oeb", 64'(io_oeb), 64'(ONES));
      check("rs3_drain_busy", 64'(busy), 64'(1));
    end
    tick();
    check("rs3_apply_oeb", 64'(io_oeb), 64'(PAT));
    check("rs3_apply_count", 64'(swcnt), 64'(2));
    tick();
    check("rs3_idle_busy", 64'(busy), 64'(0));
    check("rs3_idle_out", 64'(io_out), 64'(ONES));
    check("rs3_idle_sync", 64'(sync_out), 64'(ONES));
    check("rs3_count", 64'(swcnt), 64'(3));

    // Pad input edge reaches the harness three cycles later.
    pad_in = '0;
    tick();
    check("sync_lat1", 64'(sync_out), 64'(ONES));
    tick();
    check("sync_lat2", 64'(sync_out), 64'(ONES));
    tick();
    check("sync_lat3", 64'(sync_out), 64'(0));

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    check("arst_oeb", 64'(io_oeb), 64'(ONES));
    check("arst_count", 64'(swcnt), 64'(0));
    check("arst_busy", 64'(busy), 64'(1));
    check("arst_out", 64'(io_out), 64'(0));
    rst = 1'b0;
    for (int j = 0; j < 17; j++) tick();
    check("arst_resettle_busy", 64'(busy), 64'(0));
    check("arst_resettle_count", 64'(swcnt), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
